// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, one quotient bit per cycle, with cancel and result handshake
module add32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
endmodule

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_ready,
  input  logic             cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t           state_q;
  logic [4:0]       cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, quotient_q, remainder_q;
  logic             sgn_q, neg_a_q, neg_b_q, dbz_q;
  logic [WIDTH-1:0] shl, diff, rem_d, quo_d;
  logic             cout, take, accept, a_neg, b_neg;
  assign div_ready   = (state_q == IDLE) | ((state_q == DONE) & res_ready);
  assign accept      = div_valid & div_ready & ~cancel;
  assign res_valid   = state_q == DONE;
  assign busy        = (state_q == RUN) | (state_q == FIX);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign a_neg       = div_signed & dividend[WIDTH-1];
  assign b_neg       = div_signed & divisor[WIDTH-1];
  // The partial remainder is < divisor, so when its MSB is set the shifted value
  // exceeds 2^32 and the trial subtraction always succeeds despite the 32-bit adder.
  assign shl   = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  add32 u_add (.a_i(shl), .b_i(~dvs_q), .cin_i(1'b1), .sum_o(diff), .cout_o(cout));
  assign take  = rem_q[WIDTH-1] | cout;
  assign rem_d = take ? diff : shl;
  assign quo_d = {quo_q[WIDTH-2:0], take};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sgn_q       <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (cancel) begin
      state_q <= IDLE;
    end else if (accept) begin
      sgn_q   <= div_signed;
      neg_a_q <= a_neg;
      neg_b_q <= b_neg;
      quo_q   <= a_neg ? -dividend : dividend;
      dvs_q   <= b_neg ? -divisor : divisor;
      rem_q   <= '0;
      cnt_q   <= '0;
      if (divisor == '0) begin
        state_q     <= DONE;
        quotient_q  <= '1;
        remainder_q <= dividend;
        dbz_q       <= 1'b1;
      end else begin
        state_q <= RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          quotient_q  <= (sgn_q & (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q;
          remainder_q <= (sgn_q & neg_a_q) ? -rem_q : rem_q;
          dbz_q       <= 1'b0;
          state_q     <= DONE;
        end
        DONE: if (res_ready) state_q <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit against an arithmetic reference model
module tb_div_unit;
  logic        clk = 1'b0, resetn = 1'b0, div_valid = 1'b0, div_signed = 1'b0;
  logic        cancel = 1'b0, res_ready = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        div_ready, res_valid, div_by_zero, busy;
  logic [31:0] quotient, remainder;
  int          checks = 0, errors = 0, seen;
  logic [31:0] eq, er, ra, rb;
  logic        ez, rs;

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .resetn(resetn), .div_valid(div_valid), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor), .div_ready(div_ready), .cancel(cancel),
    .res_valid(res_valid), .res_ready(res_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
  );

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    z = 1'b0;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    div_signed = s; dividend = a; divisor = b; div_valid = 1'b1; res_ready = 1'b1;
    #1;
    chk1("div_ready_at_issue", div_ready, 1'b1);
    model(s, a, b, eq, er, ez);
    @(negedge clk);
    div_valid = 1'b0; res_ready = 1'b0;
    div_signed = ~s; dividend = $urandom; divisor = $urandom;
  endtask

  task automatic wait_res(input int lat);
    int cyc = 0;
    while (!res_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk1("div_by_zero", div_by_zero, ez);
    chk1("busy_in_done", busy, 1'b0);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk1("res_valid_after_consume", res_valid, 1'b0);
  endtask

  task automatic quiet(input string tag);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #2;
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_quotient", quotient, 32'h0);
    chk("rst_remainder", remainder, 32'h0);
    chk1("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk1("rst_div_ready", div_ready, 1'b1);
    @(negedge clk);

    issue(1'b0, 32'd100, 32'd7);
    wait_res(33);
    chk("q_100_7", quotient, 32'd14);
    chk("r_100_7", remainder, 32'd2);
    consume();

    issue(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_res(33);
    chk("q_m7_2", quotient, 32'hFFFFFFFD);
    chk("r_m7_2", remainder, 32'hFFFFFFFF);
    consume();

    issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_res(33);
    chk("q_min_m1", quotient, 32'h80000000);
    chk("r_min_m1", remainder, 32'h0);
    consume();

    for (int m = 0; m < 2; m++) begin
      issue(m[0], 32'h12345678, 32'h0);
      wait_res(0);
      chk("q_dbz", quotient, 32'hFFFFFFFF);
      chk("r_dbz", remainder, 32'h12345678);
      consume();
    end

    issue(1'b0, 32'd5000, 32'd3);
    wait_res(33);
    repeat (10) begin
      @(negedge clk);
      chk1("hold_valid", res_valid, 1'b1);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
    end
    issue(1'b1, 32'hFFFFCFC7, 32'd10);
    chk1("b2b_busy", busy, 1'b1);
    chk1("b2b_valid_dropped", res_valid, 1'b0);
    wait_res(33);
    consume();

    issue(1'b0, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    cancel = 1'b1; div_valid = 1'b1; div_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    chk1("cancel_busy", busy, 1'b0);
    chk1("cancel_valid", res_valid, 1'b0);
    chk1("cancel_ready", div_ready, 1'b1);
    @(negedge clk);
    chk1("cancel_blocks_accept", busy, 1'b0);
    cancel = 1'b0; div_valid = 1'b0;
    quiet("cancel_no_result");

    issue(1'b1, 32'hDEADBEEF, 32'd7);
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk1("mid_rst_valid", res_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_quotient", quotient, 32'h0);
    chk("mid_rst_remainder", remainder, 32'h0);
    chk1("mid_rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk1("post_rst_ready", div_ready, 1'b1);
    quiet("post_rst_no_result");

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 9);
        2: rb = 32'hFFFFFFFF;
        3: rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'h80000000;
      issue(rs, ra, rb);
      wait_res(rb == 0 ? 0 : 33);
      consume();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
